// File: rtl/retry_pkg.sv
// Shared definitions for the retry protocol blocks (retry_start, retry_end,
// retry_inorder_end). Keeps the default ID width and the retry request
// format in one place so all ends of the protocol agree.
package retry_pkg;

    // Default ID width; the in-order buffer holds 2**DefaultIdSize slots.
    localparam int unsigned DefaultIdSize = 4;

    // Retry request sent back toward retry_start.
    typedef struct packed {
        logic [DefaultIdSize-1:0] id;
    } retry_req_t;

endpackage

// File: rtl/retry_slot_mem.sv
// Reorder storage for retry_inorder_end: one slot per ID, each with a valid
// bit and a payload. One write port (addressed by the incoming ID) and one
// read/clear port (addressed by the head pointer). The occupancy bit of the
// write address is reported so the parent can detect duplicates.
module retry_slot_mem
    import retry_pkg::*;
#(
    parameter type         DataType = logic,
    parameter int unsigned IDSize   = DefaultIdSize
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wrEn,
    input  logic [IDSize-1:0] i_wrId,
    input  DataType           i_wrData,
    output logic              o_wrOccupied,
    input  logic [IDSize-1:0] i_rdId,
    input  logic              i_rdClear,
    output logic              o_rdValid,
    output DataType           o_rdData
);

    localparam int unsigned Depth = 1 << IDSize;

    logic [Depth-1:0] r_slotValid;
    DataType          r_slotData [Depth];

    // Write a new element into its slot and free the head slot once emitted.
    // The parent never writes an occupied slot, so a write and a clear never
    // target the same slot in one cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_slotValid <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                r_slotData[i] <= '0;
            end
        end else begin
            if (i_rdClear) begin
                r_slotValid[i_rdId] <= 1'b0;
            end
            if (i_wrEn) begin
                r_slotValid[i_wrId] <= 1'b1;
                r_slotData[i_wrId]  <= i_wrData;
            end
        end
    end

    // Read ports are pure register lookups, so downstream sees no
    // combinational path from the upstream inputs.
    always_comb begin
        o_wrOccupied = r_slotValid[i_wrId];
        o_rdValid    = r_slotValid[i_rdId];
        o_rdData     = r_slotData[i_rdId];
    end

endmodule

// File: rtl/retry_inorder_end.sv
// Receiving end of the retry protocol. Good elements are parked by ID and
// released strictly in ID order; faulty elements are dropped and their ID is
// handed back to retry_start through a registered retry channel. A good
// element whose slot is still occupied is a duplicate and is discarded.
module retry_inorder_end
    import retry_pkg::*;
#(
    parameter type         DataType = logic,
    parameter int unsigned IDSize   = DefaultIdSize
) (
    input  logic              clk,
    input  logic              rst_n,
    input  DataType           data_i,
    input  logic [IDSize-1:0] id_i,
    input  logic              needs_retry_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [IDSize-1:0] retry_id_o,
    output logic              retry_valid_o,
    input  logic              retry_ready_i,
    output logic              dropped_o
);

    logic [IDSize-1:0] r_head;
    logic              r_retryValid;
    logic [IDSize-1:0] r_retryId;

    logic    w_goodIn;
    logic    w_retryIn;
    logic    w_retryFree;
    logic    w_occupied;
    logic    w_wrEn;
    logic    w_headValid;
    logic    w_emit;
    DataType w_headData;

    // Decode the upstream element and the handshakes. ready_o only looks at
    // needs_retry_i and the retry register, never at valid_i or ready_i.
    always_comb begin
        w_goodIn    = valid_i && !needs_retry_i;
        w_retryIn   = valid_i && needs_retry_i;
        w_retryFree = !r_retryValid || retry_ready_i;
        ready_o     = needs_retry_i ? w_retryFree : 1'b1;
        w_wrEn      = w_goodIn && !w_occupied;
        dropped_o   = w_goodIn && w_occupied;
        w_emit      = w_headValid && ready_i;
        valid_o     = w_headValid;
        data_o      = w_headData;
    end

    retry_slot_mem #(
        .DataType (DataType),
        .IDSize   (IDSize)
    ) u_slotMem (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wrEn       (w_wrEn),
        .i_wrId       (id_i),
        .i_wrData     (data_i),
        .o_wrOccupied (w_occupied),
        .i_rdId       (r_head),
        .i_rdClear    (w_emit),
        .o_rdValid    (w_headValid),
        .o_rdData     (w_headData)
    );

    // Advance the head pointer on every downstream handshake; it wraps
    // naturally at 2**IDSize.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_head <= '0;
        end else if (w_emit) begin
            r_head <= r_head + 1'b1;
        end
    end

    // Retry output register: a new request may load in the same cycle the
    // old one is handed off, in which case valid stays high with the new ID.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_retryValid <= 1'b0;
            r_retryId    <= '0;
        end else if (w_retryIn && w_retryFree) begin
            r_retryValid <= 1'b1;
            r_retryId    <= id_i;
        end else if (retry_ready_i) begin
            r_retryValid <= 1'b0;
        end
    end

    assign retry_valid_o = r_retryValid;
    assign retry_id_o    = r_retryId;

endmodule

// File: tb/tb_retry_inorder_end.sv
// Testbench for retry_inorder_end with 8-bit payloads and 4-bit IDs.
// Stimulus tasks push expected payloads / retry IDs into queues; monitor
// processes pop and compare whenever the DUT completes a handshake.
module tb_retry_inorder_end;

    typedef logic [7:0] data_t;

    logic       clock = 1'b0;
    logic       reset;
    data_t      dataIn;
    logic [3:0] idIn;
    logic       needsRetry;
    logic       validIn;
    logic       readyOut;
    data_t      dataOut;
    logic       validOut;
    logic       readyIn;
    logic [3:0] retryIdOut;
    logic       retryValidOut;
    logic       retryReady;
    logic       droppedOut;

    int         checks = 0;
    int         errors = 0;
    data_t      expData[$];
    logic [3:0] expRetry[$];
    data_t      expV;
    logic [3:0] expR;
    logic       dropSeen;

    retry_inorder_end #(
        .DataType (data_t),
        .IDSize   (4)
    ) dut (
        .clk           (clock),
        .rst_n         (reset),
        .data_i        (dataIn),
        .id_i          (idIn),
        .needs_retry_i (needsRetry),
        .valid_i       (validIn),
        .ready_o       (readyOut),
        .data_o        (dataOut),
        .valid_o       (validOut),
        .ready_i       (readyIn),
        .retry_id_o    (retryIdOut),
        .retry_valid_o (retryValidOut),
        .retry_ready_i (retryReady),
        .dropped_o     (droppedOut)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Compare one observed value against the expected one.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, required);
        end
    endtask

    // Present one element for one cycle; starts just after a rising edge and
    // returns just after the next one. Reports dropped_o seen mid-cycle.
    task automatic applyStimulus(input logic [3:0] id, input data_t d, input logic retry, output logic drop);
        validIn    = 1'b1;
        idIn       = id;
        dataIn     = d;
        needsRetry = retry;
        @(negedge clock);
        drop = droppedOut;
        @(posedge clock);
        #1;
        validIn    = 1'b0;
        needsRetry = 1'b0;
    endtask

    // Wait (bounded) until every expected payload has been emitted.
    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (expData.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        #1;
        checkOutput(name, expData.size(), 0);
    endtask

    // Output monitor: every downstream handshake must match the next
    // expected payload.
    always @(negedge clock) begin
        if (!reset && validOut && readyIn) begin
            checks++;
            if (expData.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedOutput: actual %0h, required none", dataOut);
            end else begin
                expV = expData.pop_front();
                if (dataOut !== expV) begin
                    errors++;
                    $display("[TB] FAIL outputData: actual %0h, required %0h", dataOut, expV);
                end
            end
        end
    end

    // Retry monitor: every retry handshake must match the next expected ID.
    always @(negedge clock) begin
        if (!reset && retryValidOut && retryReady) begin
            checks++;
            if (expRetry.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedRetry: actual %0h, required none", retryIdOut);
            end else begin
                expR = expRetry.pop_front();
                if (retryIdOut !== expR) begin
                    errors++;
                    $display("[TB] FAIL retryId: actual %0h, required %0h", retryIdOut, expR);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        dataIn     = '0;
        idIn       = '0;
        needsRetry = 1'b0;
        validIn    = 1'b0;
        readyIn    = 1'b0;
        retryReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("resetValidO", validOut, 0);
        checkOutput("resetDataO", dataOut, 0);
        checkOutput("resetReadyO", readyOut, 1);
        checkOutput("resetRetryValid", retryValidOut, 0);
        checkOutput("resetRetryId", retryIdOut, 0);
        checkOutput("resetDropped", droppedOut, 0);
        reset = 1'b0;

        // In-order stream 0..15 then 0..3, one per cycle, head wraps.
        readyIn = 1'b1;
        for (int i = 0; i < 16; i++) expData.push_back(data_t'(8'h10 + i));
        for (int i = 0; i < 4; i++) expData.push_back(data_t'(8'h20 + i));
        applyStimulus(4'd0, 8'h10, 1'b0, dropSeen);
        checkOutput("latencyValid", validOut, 1);
        checkOutput("latencyData", dataOut, 8'h10);
        for (int i = 1; i < 16; i++) applyStimulus(4'(i), data_t'(8'h10 + i), 1'b0, dropSeen);
        for (int i = 0; i < 4; i++) applyStimulus(4'(i), data_t'(8'h20 + i), 1'b0, dropSeen);
        waitDrain("streamDrain");

        // Reset mid-traffic: parked elements and a pending retry are lost.
        readyIn = 1'b0;
        applyStimulus(4'd4, 8'h44, 1'b0, dropSeen);
        applyStimulus(4'd9, 8'h99, 1'b1, dropSeen);
        checkOutput("preResetValid", validOut, 1);
        checkOutput("preResetRetry", retryValidOut, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midResetValidO", validOut, 0);
        checkOutput("midResetReadyO", readyOut, 1);
        checkOutput("midResetRetryValid", retryValidOut, 0);
        checkOutput("midResetRetryId", retryIdOut, 0);
        checkOutput("midResetDataO", dataOut, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Out-of-order good elements; head restarts at 0 after reset.
        readyIn = 1'b1;
        expData.push_back(8'hA0);
        expData.push_back(8'hA1);
        expData.push_back(8'hA2);
        applyStimulus(4'd2, 8'hA2, 1'b0, dropSeen);
        checkOutput("oooWait2", validOut, 0);
        applyStimulus(4'd1, 8'hA1, 1'b0, dropSeen);
        checkOutput("oooWait1", validOut, 0);
        applyStimulus(4'd0, 8'hA0, 1'b0, dropSeen);
        checkOutput("oooRelease", validOut, 1);
        waitDrain("oooDrain");

        // Retry of ID 3 held by retry backpressure; ID 5 retry must wait.
        validIn    = 1'b1;
        idIn       = 4'd3;
        dataIn     = 8'hEE;
        needsRetry = 1'b1;
        @(negedge clock);
        checkOutput("retryFirstReady", readyOut, 1);
        @(posedge clock);
        #1;
        expRetry.push_back(4'd3);
        idIn = 4'd5;
        repeat (4) begin
            @(negedge clock);
            checkOutput("retryHoldValid", retryValidOut, 1);
            checkOutput("retryHoldId", retryIdOut, 3);
            checkOutput("retrySecondBlocked", readyOut, 0);
        end
        @(posedge clock);
        #1;
        retryReady = 1'b1;
        #1;
        checkOutput("retrySecondReady", readyOut, 1);
        expRetry.push_back(4'd5);
        @(posedge clock);
        #1;
        validIn    = 1'b0;
        needsRetry = 1'b0;
        checkOutput("retryReloadValid", retryValidOut, 1);
        checkOutput("retryReloadId", retryIdOut, 5);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        checkOutput("retryCleared", retryValidOut, 0);

        // Replayed ID 3 must come out between ID 2 (already emitted) and ID 4.
        expData.push_back(8'hB3);
        expData.push_back(8'hB4);
        expData.push_back(8'hB5);
        applyStimulus(4'd4, 8'hB4, 1'b0, dropSeen);
        checkOutput("waitForReplay", validOut, 0);
        applyStimulus(4'd3, 8'hB3, 1'b0, dropSeen);
        applyStimulus(4'd5, 8'hB5, 1'b0, dropSeen);
        waitDrain("replayDrain");

        // Duplicate of ID 7 before emission: one drop, first payload wins.
        readyIn = 1'b0;
        expData.push_back(8'hC6);
        expData.push_back(8'hC7);
        applyStimulus(4'd7, 8'hC7, 1'b0, dropSeen);
        checkOutput("dupFirstNoDrop", dropSeen, 0);
        applyStimulus(4'd7, 8'hC8, 1'b0, dropSeen);
        checkOutput("dupSecondDrop", dropSeen, 1);
        @(negedge clock);
        checkOutput("dupPulseOnce", droppedOut, 0);
        @(posedge clock);
        #1;
        applyStimulus(4'd6, 8'hC6, 1'b0, dropSeen);
        readyIn = 1'b1;
        waitDrain("dupDrain");

        // Backpressure with every slot full; only duplicates arrive meanwhile.
        readyIn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expData.push_back(data_t'(8'hD0 + ((8 + i) % 16)));
            applyStimulus(4'((8 + i) % 16), data_t'(8'hD0 + ((8 + i) % 16)), 1'b0, dropSeen);
        end
        validIn = 1'b1;
        idIn    = 4'd10;
        dataIn  = 8'hFF;
        repeat (20) begin
            @(negedge clock);
            checkOutput("bpReady", readyOut, 1);
            checkOutput("bpDropped", droppedOut, 1);
            checkOutput("bpValid", validOut, 1);
            checkOutput("bpHeadData", dataOut, 8'hD8);
        end
        @(posedge clock);
        #1;
        validIn = 1'b0;
        readyIn = 1'b1;
        waitDrain("bpDrain");

        checkOutput("retryQueueEmpty", expRetry.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/retry_inorder_end.md
# retry_inorder_end

Receiving end of the retry protocol that restores program order. It sits after `time_DMR_end` and returns the retry requests to `retry_start`. Each incoming element carries an ID. Good elements are parked in a slot indexed by that ID. Elements flagged `needs_retry_i` are dropped and their ID is sent back on the retry channel. Downstream sees elements strictly in ID order 0, 1, 2, …, wrapping at 2^IDSize, regardless of how many retries occurred.

## Interface
- `DataType`, default `logic`: payload type.
- `IDSize`, default 4: ID width. The buffer holds 2^IDSize slots.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-high.
- `data_i` in `DataType`: upstream payload.
- `id_i` in `IDSize`: upstream ID.
- `needs_retry_i` in 1: upstream element is faulty and must be replayed.
- `valid_i` in 1 / `ready_o` out 1: upstream handshake.
- `data_o` out `DataType`: in-order payload.
- `valid_o` out 1 / `ready_i` in 1: downstream handshake.
- `retry_id_o` out `IDSize`: ID to replay.
- `retry_valid_o` out 1 / `retry_ready_i` in 1: retry handshake toward `retry_start`.
- `dropped_o` out 1: one-cycle pulse when a duplicate good element is discarded.

## Operation
- **State**
  - `slot_valid[2^IDSize]` and `slot_data[2^IDSize]`.
  - `head` (`IDSize` bits), the next ID to emit.
  - Retry output register: `retry_valid_q`, `retry_id_q`.
- **Good element** (`valid_i && !needs_retry_i`):
  - `ready_o` is 1.
  - If `slot_valid[id_i]` is 0, write the slot and set its valid bit.
  - Otherwise discard the element and pulse `dropped_o`. Storage is unchanged.
- **Retry element** (`valid_i && needs_retry_i`):
  - `ready_o = !retry_valid_q || retry_ready_i`.
  - On handshake, load `retry_id_q <= id_i` and set `retry_valid_q <= 1`. The payload is discarded.
- **Retry channel**: `retry_valid_q` clears on `retry_ready_i` unless reloaded in the same cycle. Once asserted, `retry_valid_o` and `retry_id_o` stay stable until the handshake.
- **Output**
  - `valid_o = slot_valid[head]`, `data_o = slot_data[head]`.
  - On `valid_o && ready_i`: clear `slot_valid[head]` and set `head <= head + 1`, wrapping modulo 2^IDSize.
- **Upstream contract**: `retry_start` never has more than 2^IDSize IDs outstanding. A slot is therefore only rewritten after it has been emitted.
- **Simultaneous events**
  - Write to slot X in the same cycle X is emitted: treated as a duplicate, because the slot is still occupied.
  - Write to slot `head+1` while `head` is emitted: both take effect.
  - Retry reload and retry handshake in the same cycle: the new ID is registered and `retry_valid_o` stays 1.
- **Reset**, at any time:
  - All `slot_valid`, `head`, `retry_valid_q` and `retry_id_q` clear to 0.
  - `slot_data` clears to `'0`.
  - In-flight elements are lost.

## Timing
- **Reset values**: `valid_o=0`, `data_o='0`, `retry_valid_o=0`, `retry_id_o=0`, `dropped_o=0`, `ready_o=1`.
- **Accept to `valid_o`**: 1 cycle when the ID equals `head`. Otherwise the element waits until all earlier IDs have been emitted.
- **Retry handshake to `retry_valid_o`**: 1 cycle.
- **Combinational paths**:
  - `ready_o` depends on `needs_retry_i`, `retry_valid_q` and `retry_ready_i` only. There is no path from `valid_i` or `ready_i`.
  - `valid_o` and `data_o` are driven from registers only.
- **Throughput**: 1 element in and 1 element out per cycle. Sustained retries run at 1 per cycle when `retry_ready_i` is held at 1.

## Structure
- Shared package `retry_pkg`: ID width default and the `retry_req_t {id}` struct, shared with `retry_start` and `retry_end`.
- One sub-module is natural: `retry_slot_mem`, holding the valid bits and data array.
  - One write port (ID, data).
  - One read/clear port at `head`.
  - Reports the occupancy bit for the write ID.
- Top level contains `head`, the retry register and the handshake logic. Total 150–250 lines.

## Test plan
- **Reset mid-traffic**: after reset, `valid_o=0`, `ready_o=1`, `retry_valid_o=0`, `head=0`.
- **In-order stream**: IDs 0..15 then 0..3 with `ready_i=1` → outputs in the same order at 1 per cycle, each 1 cycle after accept; `head` wraps 15→0.
- **Out-of-order good elements**: IDs 2, 1, 0, data `0xA2`, `0xA1`, `0xA0` → `valid_o` stays low until ID 0 arrives, then `0xA0`, `0xA1`, `0xA2` on consecutive cycles.
- **Retry of ID 3**:
  - Stimulus: ID 3 with `needs_retry_i=1` while `retry_ready_i=0` for 4 cycles.
  - `retry_id_o=3` and `retry_valid_o` held stable throughout.
  - A second retry (ID 5) sees `ready_o=0` until the first handshake.
  - Replayed ID 3 is emitted after ID 2 and before ID 4.
- **Duplicate**: ID 7 accepted twice before emission → `dropped_o` pulses once and only the first payload is emitted.
- **Backpressure**: `ready_i=0` for 20 cycles with IDs 0..15 filled → upstream remains accepting duplicates only; releasing `ready_i` drains all 16 in order.
